// File: rtl/ball_engine.sv
// ---------------------------------------------------------------------------
// ball_engine
//
// Ball integrator for a pong-style game. Keeps a fixed-point ball position
// and an angular heading, moves the ball once per move_en tick using sin/cos
// values supplied by an external registered lookup, reflects off paddles and
// (optionally) off the top/bottom walls, and runs the serve sequence:
//   IDLE -> SERVE (countdown) -> SETTLE -> PLAY -> (SETTLE | OUT) ...
// SETTLE gives the one-cycle lookup time to catch up with a new heading
// before the ball moves again. OUT lasts one clock, pulses the score output
// and re-serves automatically.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset
//   move_en      one-cycle movement tick
//   serve        level request to start a serve from IDLE
//   speed_init   speed loaded at launch
//   entropy      random bits: launch quadrant/heading and bounce jitter
//   sin_i/cos_i  signed sin/cos of theta_o, one cycle behind theta_o
//   lpaddle      row mask of the left paddle (column 0)
//   rpaddle      row mask of the right paddle (column W-1)
//   x, y         ball cell coordinates
//   theta_o      current heading (2^THETA_WIDTH steps per turn)
//   speed_o      current speed
//   in_play      high while in SETTLE or PLAY
//   score_left   one-cycle pulse: ball left through the right edge
//   score_right  one-cycle pulse: ball left through the left edge
//
// THETA_WIDTH must be at least 6 (launch heading is built from 6 bits).
// ---------------------------------------------------------------------------
module ball_engine #(
  parameter int POS_BITS    = 5,
  parameter int FRAC_BITS   = 16,
  parameter int THETA_WIDTH = 6,
  parameter int SPEED_BITS  = 4,
  parameter int SPEED_STEP  = 1,
  parameter int SPEED_MAX   = 15,
  parameter int SERVE_TICKS = 1000,
  parameter int WALL_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        move_en,
  input  logic                        serve,
  input  logic [SPEED_BITS-1:0]       speed_init,
  input  logic [4:0]                  entropy,
  input  logic signed [7:0]           sin_i,
  input  logic signed [7:0]           cos_i,
  input  logic [(1<<POS_BITS)-1:0]    lpaddle,
  input  logic [(1<<POS_BITS)-1:0]    rpaddle,
  output logic [POS_BITS-1:0]         x,
  output logic [POS_BITS-1:0]         y,
  output logic [THETA_WIDTH-1:0]      theta_o,
  output logic [SPEED_BITS-1:0]       speed_o,
  output logic                        in_play,
  output logic                        score_left,
  output logic                        score_right
);

  localparam int PW     = POS_BITS + FRAC_BITS;
  localparam int PROD_W = 8 + SPEED_BITS + 1;
  localparam int CNT_W  = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [CNT_W-1:0]       CNT_RELOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [PW-1:0]          CENTRE     = {1'b1, {(PW-1){1'b0}}};
  localparam logic [POS_BITS-1:0]    EDGE_HI    = {POS_BITS{1'b1}};
  localparam logic [THETA_WIDTH-1:0] HALF_TURN  = {1'b1, {(THETA_WIDTH-1){1'b0}}};
  localparam logic [SPEED_BITS:0]    SPEED_INC  = (SPEED_BITS+1)'(SPEED_STEP);
  localparam logic [SPEED_BITS:0]    SPEED_CAP  = (SPEED_BITS+1)'(SPEED_MAX);
  localparam bit                     BOUNCE_WALLS = (WALL_MODE != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PW-1:0]          posX_q, posX_d;
  logic [PW-1:0]          posY_q, posY_d;
  logic [THETA_WIDTH-1:0] theta_q, theta_d;
  logic [SPEED_BITS-1:0]  speed_q, speed_d;
  logic                   scoreLeft_q, scoreLeft_d;
  logic                   scoreRight_q, scoreRight_d;

  // Velocity: lookup value times the (unsigned) speed, then sign-extended to
  // the accumulator width plus one guard bit. The guard bit of the sum flags
  // a crossing below zero or past the far edge of the field.
  logic signed [SPEED_BITS:0] speedSigned;
  logic signed [PROD_W-1:0]   dxProd, dyProd;
  logic [PW:0]                dxExt, dyExt;
  logic [PW:0]                nextX, nextY;
  logic [POS_BITS-1:0]        nextXCell, nextYCell;
  logic                       nextYCross, nextXCross;

  assign speedSigned = $signed({1'b0, speed_q});
  assign dxProd      = PROD_W'(cos_i) * PROD_W'(speedSigned);
  assign dyProd      = PROD_W'(sin_i) * PROD_W'(speedSigned);
  assign dxExt       = {{(PW+1-PROD_W){dxProd[PROD_W-1]}}, dxProd};
  assign dyExt       = {{(PW+1-PROD_W){dyProd[PROD_W-1]}}, dyProd};
  assign nextX       = {1'b0, posX_q} + dxExt;
  assign nextY       = {1'b0, posY_q} + dyExt;
  assign nextXCell   = nextX[PW-1 -: POS_BITS];
  assign nextYCell   = nextY[PW-1 -: POS_BITS];
  assign nextXCross  = nextX[PW];
  assign nextYCross  = nextY[PW];

  // Direction comes from the heading itself rather than the sign of cos_i,
  // so edge detection never depends on lookup timing.
  logic movingRight;
  logic hitLeftEdge, hitRightEdge;

  assign movingRight  = (theta_q[THETA_WIDTH-1 -: 2] == 2'b00) ||
                        (theta_q[THETA_WIDTH-1 -: 2] == 2'b11);
  assign hitLeftEdge  = !movingRight && (nextXCross || (nextXCell == '0));
  assign hitRightEdge =  movingRight && (nextXCross || (nextXCell == EDGE_HI));

  // Reflection arithmetic wraps naturally at THETA_WIDTH bits.
  logic [THETA_WIDTH-1:0] bounce, hTheta, vTheta;

  assign bounce = {{(THETA_WIDTH-3){entropy[2]}}, entropy[2:0]};
  assign hTheta = HALF_TURN - theta_q + bounce;
  assign vTheta = bounce - theta_q;

  logic [SPEED_BITS:0]   speedSum;
  logic [SPEED_BITS-1:0] speedBumped;

  assign speedSum    = {1'b0, speed_q} + SPEED_INC;
  assign speedBumped = (speedSum > SPEED_CAP) ? SPEED_CAP[SPEED_BITS-1:0]
                                              : speedSum[SPEED_BITS-1:0];

  // Launch heading: quadrant code from entropy[4:3] picks one of the four
  // octants that point clearly left or right, entropy[2:0] the offset.
  logic [2:0]             launchQuad;
  logic [5:0]             launchSix;
  logic [THETA_WIDTH-1:0] launchTheta;

  always_comb begin
    launchQuad = 3'b000;
    case (entropy[4:3])
      2'b00:   launchQuad = 3'b000;
      2'b01:   launchQuad = 3'b011;
      2'b10:   launchQuad = 3'b100;
      default: launchQuad = 3'b111;
    endcase
  end

  assign launchSix   = {launchQuad, entropy[2:0]};
  assign launchTheta = THETA_WIDTH'(launchSix) << (THETA_WIDTH - 6);

  // Next-state logic. Edge (paddle/out) decisions outrank walls; a reflected
  // ball keeps its old position and passes through SETTLE so the lookup
  // delivers sin/cos for the new heading before the next move.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    posX_d       = posX_q;
    posY_d       = posY_q;
    theta_d      = theta_q;
    speed_d      = speed_q;
    scoreLeft_d  = 1'b0;
    scoreRight_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        posX_d = CENTRE;
        posY_d = CENTRE;
        if (serve) begin
          state_d = ST_SERVE;
          count_d = CNT_RELOAD;
        end
      end

      ST_SERVE: begin
        if (move_en) begin
          if (count_q == '0) begin
            speed_d = speed_init;
            theta_d = launchTheta;
            state_d = ST_SETTLE;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end

      ST_SETTLE: begin
        if (move_en) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (move_en) begin
          if (hitLeftEdge) begin
            if (lpaddle[nextYCell]) begin
              theta_d = hTheta;
              speed_d = speedBumped;
              state_d = ST_SETTLE;
            end else begin
              scoreRight_d = 1'b1;
              state_d      = ST_OUT;
            end
          end else if (hitRightEdge) begin
            if (rpaddle[nextYCell]) begin
              theta_d = hTheta;
              speed_d = speedBumped;
              state_d = ST_SETTLE;
            end else begin
              scoreLeft_d = 1'b1;
              state_d     = ST_OUT;
            end
          end else if (BOUNCE_WALLS && nextYCross) begin
            theta_d = vTheta;
            state_d = ST_SETTLE;
          end else begin
            // In wrap mode dropping the guard bit is the modulo-W wrap.
            posX_d = nextX[PW-1:0];
            posY_d = nextY[PW-1:0];
          end
        end
      end

      ST_OUT: begin
        posX_d  = CENTRE;
        posY_d  = CENTRE;
        count_d = CNT_RELOAD;
        state_d = ST_SERVE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      posX_q       <= CENTRE;
      posY_q       <= CENTRE;
      theta_q      <= '0;
      speed_q      <= '0;
      scoreLeft_q  <= 1'b0;
      scoreRight_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      posX_q       <= posX_d;
      posY_q       <= posY_d;
      theta_q      <= theta_d;
      speed_q      <= speed_d;
      scoreLeft_q  <= scoreLeft_d;
      scoreRight_q <= scoreRight_d;
    end
  end

  assign x           = posX_q[PW-1 -: POS_BITS];
  assign y           = posY_q[PW-1 -: POS_BITS];
  assign theta_o     = theta_q;
  assign speed_o     = speed_q;
  assign in_play     = (state_q == ST_SETTLE) || (state_q == ST_PLAY);
  assign score_left  = scoreLeft_q;
  assign score_right = scoreRight_q;

endmodule

// File: tb/tb_ball_engine.sv
// ---------------------------------------------------------------------------
// tb_ball_engine
//
// Directed bench for ball_engine. Two instances share all stimulus: dutA
// bounces off the top/bottom walls, dutB wraps. Each instance gets its own
// registered sin/cos source whose magnitudes the bench picks per scenario and
// whose signs follow the heading, so trajectories are easy to reason about.
// ---------------------------------------------------------------------------
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        moveEn;
  logic        serve;
  logic [3:0]  speedInit;
  logic [4:0]  entropy;
  logic [31:0] lpaddle, rpaddle;

  logic signed [7:0] sinA, cosA, sinB, cosB;
  logic [4:0] xA, yA, xB, yB;
  logic [5:0] thetaA, thetaB;
  logic [3:0] speedA, speedB;
  logic       inPlayA, inPlayB;
  logic       scoreLA, scoreRA, scoreLB, scoreRB;

  int cosMag;
  int sinMag;
  int testsRun;
  int testsFailed;

  always #5 clk = ~clk;

  // Sign convention: right for heading octant pairs 00/11, down for MSB 0.
  function automatic logic signed [7:0] lutCos(input logic [5:0] th, input int mag);
    logic signed [7:0] m;
    m = 8'(mag);
    if (th[5:4] == 2'b00 || th[5:4] == 2'b11) return m;
    return -m;
  endfunction

  function automatic logic signed [7:0] lutSin(input logic [5:0] th, input int mag);
    logic signed [7:0] m;
    m = 8'(mag);
    if (!th[5]) return m;
    return -m;
  endfunction

  // One-cycle registered lookup, one per instance.
  always @(posedge clk) begin
    cosA <= lutCos(thetaA, cosMag);
    sinA <= lutSin(thetaA, sinMag);
    cosB <= lutCos(thetaB, cosMag);
    sinB <= lutSin(thetaB, sinMag);
  end

  ball_engine #(.SERVE_TICKS(4), .WALL_MODE(1)) dutA (
    .clk(clk), .reset_n(reset_n), .move_en(moveEn), .serve(serve),
    .speed_init(speedInit), .entropy(entropy), .sin_i(sinA), .cos_i(cosA),
    .lpaddle(lpaddle), .rpaddle(rpaddle), .x(xA), .y(yA), .theta_o(thetaA),
    .speed_o(speedA), .in_play(inPlayA), .score_left(scoreLA),
    .score_right(scoreRA)
  );

  ball_engine #(.SERVE_TICKS(4), .WALL_MODE(0)) dutB (
    .clk(clk), .reset_n(reset_n), .move_en(moveEn), .serve(serve),
    .speed_init(speedInit), .entropy(entropy), .sin_i(sinB), .cos_i(cosB),
    .lpaddle(lpaddle), .rpaddle(rpaddle), .x(xB), .y(yB), .theta_o(thetaB),
    .speed_o(speedB), .in_play(inPlayB), .score_left(scoreLB),
    .score_right(scoreRB)
  );

  // Reset held two cycles, then move_en ticks in IDLE must change nothing.
  task automatic test_reset();
    reset_n = 1'b0; moveEn = 1'b0; serve = 1'b0;
    speedInit = 4'd0; entropy = 5'd0; lpaddle = '1; rpaddle = '1;
    cosMag = 0; sinMag = 0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({xA, yA, thetaA, speedA, inPlayA, scoreLA, scoreRA} !==
        {5'd16, 5'd16, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state A: x=%0d y=%0d th=%0d sp=%0d ip=%b sl=%b sr=%b, want 16 16 0 0 0 0 0",
               xA, yA, thetaA, speedA, inPlayA, scoreLA, scoreRA);
    end
    testsRun++;
    if ({xB, yB, thetaB, inPlayB} !== {5'd16, 5'd16, 6'd0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state B: x=%0d y=%0d th=%0d ip=%b, want 16 16 0 0",
               xB, yB, thetaB, inPlayB);
    end
    reset_n = 1'b1;
    moveEn  = 1'b1;
    repeat (3) @(negedge clk);
    moveEn = 1'b0;
    testsRun++;
    if ({xA, yA, inPlayA, thetaA} !== {5'd16, 5'd16, 1'b0, 6'd0}) begin
      testsFailed++;
      $display("[TB] FAIL idle_ignores_move: x=%0d y=%0d ip=%b th=%0d, want 16 16 0 0",
               xA, yA, inPlayA, thetaA);
    end
  endtask

  // Countdown of 4 ticks with idle gaps; entropy 01_010 gives heading 26.
  task automatic test_serve();
    speedInit = 4'd3;
    entropy   = 5'b01_010;
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    for (int i = 0; i < 3; i++) begin
      moveEn = 1'b1;
      @(negedge clk) moveEn = 1'b0;
      @(negedge clk);
    end
    testsRun++;
    if ({inPlayA, thetaA, speedA} !== {1'b0, 6'd0, 4'd0}) begin
      testsFailed++;
      $display("[TB] FAIL serve_before_4th: ip=%b th=%0d sp=%0d, want 0 0 0",
               inPlayA, thetaA, speedA);
    end
    moveEn = 1'b1;
    @(negedge clk) moveEn = 1'b0;
    testsRun++;
    if ({inPlayA, thetaA, speedA, xA, yA} !== {1'b1, 6'b011010, 4'd3, 5'd16, 5'd16}) begin
      testsFailed++;
      $display("[TB] FAIL serve_launch: ip=%b th=%0d sp=%0d x=%0d y=%0d, want 1 26 3 16 16",
               inPlayA, thetaA, speedA, xA, yA);
    end
  endtask

  // Heading 26 travels left on row 16; only lpaddle bit 16 is set and the
  // bounce is -1, so the hit gives 32-26-1 = 5 with speed 3 -> 4 at x=1.
  task automatic test_paddle_hit();
    int n;
    cosMag  = 127;
    sinMag  = 0;
    entropy = 5'b00_111;
    lpaddle = 32'h1 << 16;
    rpaddle = '1;
    moveEn  = 1'b1;
    n = 0;
    while (thetaA === 6'd26 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if (n >= 5000) begin
      testsFailed++;
      $display("[TB] FAIL left_hit_timeout: theta=%0d after %0d cycles, want change", thetaA, n);
    end
    testsRun++;
    if ({thetaA, speedA, xA, yA, inPlayA, scoreRA} !==
        {6'd5, 4'd4, 5'd1, 5'd16, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL left_hit: th=%0d sp=%0d x=%0d y=%0d ip=%b sr=%b, want 5 4 1 16 1 0",
               thetaA, speedA, xA, yA, inPlayA, scoreRA);
    end
    entropy = 5'd0;
  endtask

  // Right paddle hit (32-5 = 27), then the left paddle loses row 16 -> miss.
  task automatic test_miss();
    int n;
    n = 0;
    while (thetaA === 6'd5 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({thetaA, speedA, xA} !== {6'd27, 4'd5, 5'd30}) begin
      testsFailed++;
      $display("[TB] FAIL right_hit: th=%0d sp=%0d x=%0d after %0d cycles, want 27 5 30",
               thetaA, speedA, xA, n);
    end
    lpaddle = ~(32'h1 << 16);
    n = 0;
    while (scoreRA !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({scoreRA, scoreLA, inPlayA} !== {1'b1, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL miss_pulse: sr=%b sl=%b ip=%b after %0d cycles, want 1 0 0",
               scoreRA, scoreLA, inPlayA, n);
    end
    speedInit = 4'd10;
    entropy   = 5'd0;
    @(negedge clk);
    testsRun++;
    if ({scoreRA, xA, yA, inPlayA, speedA} !== {1'b0, 5'd16, 5'd16, 1'b0, 4'd5}) begin
      testsFailed++;
      $display("[TB] FAIL miss_recentre: sr=%b x=%0d y=%0d ip=%b sp=%0d, want 0 16 16 0 5",
               scoreRA, xA, yA, inPlayA, speedA);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if ({inPlayA, speedA} !== {1'b0, 4'd5}) begin
      testsFailed++;
      $display("[TB] FAIL reserve_countdown: ip=%b sp=%0d, want 0 5", inPlayA, speedA);
    end
    @(negedge clk);
    testsRun++;
    if ({inPlayA, speedA, thetaA} !== {1'b1, 4'd10, 6'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reserve_launch: ip=%b sp=%0d th=%0d, want 1 10 0",
               inPlayA, speedA, thetaA);
    end
  endtask

  // 20 hits between full paddles from speed 10; heading alternates 32/0.
  // Then a right-edge miss, auto re-serve, and reset in mid-flight.
  task automatic test_saturation();
    int n;
    logic [5:0] prevTheta;
    logic [5:0] wantTheta;
    int wantSpeed;
    lpaddle   = '1;
    rpaddle   = '1;
    prevTheta = 6'd0;
    for (int hit = 1; hit <= 20; hit++) begin
      n = 0;
      while (thetaA === prevTheta && n < 4000) begin
        @(negedge clk);
        n++;
      end
      wantTheta = (hit % 2 == 1) ? 6'd32 : 6'd0;
      wantSpeed = (10 + hit > 15) ? 15 : 10 + hit;
      testsRun++;
      if ({thetaA, speedA} !== {wantTheta, 4'(wantSpeed)}) begin
        testsFailed++;
        $display("[TB] FAIL speed_hit_%0d: th=%0d sp=%0d, want %0d %0d",
                 hit, thetaA, speedA, wantTheta, wantSpeed);
      end
      prevTheta = wantTheta;
    end
    rpaddle = '0;
    n = 0;
    while (scoreLA !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({scoreLA, scoreRA, inPlayA} !== {1'b1, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL right_miss: sl=%b sr=%b ip=%b after %0d cycles, want 1 0 0",
               scoreLA, scoreRA, inPlayA, n);
    end
    @(negedge clk);
    testsRun++;
    if (scoreLA !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL score_left_width: sl=%b, want 0", scoreLA);
    end
    repeat (300) @(negedge clk);
    testsRun++;
    if ({inPlayA, speedA} !== {1'b1, 4'd10}) begin
      testsFailed++;
      $display("[TB] FAIL relaunch_speed: ip=%b sp=%0d, want 1 10", inPlayA, speedA);
    end
    reset_n = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({xA, yA, thetaA, speedA, inPlayA} !== {5'd16, 5'd16, 6'd0, 4'd0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: x=%0d y=%0d th=%0d sp=%0d ip=%b, want 16 16 0 0 0",
               xA, yA, thetaA, speedA, inPlayA);
    end
    reset_n = 1'b1;
    moveEn  = 1'b0;
  endtask

  // Heading 56 (right, up) with no horizontal motion. A bounces to 8 at
  // y=0 while B wraps to y=31 keeping 56; later A bounces 8 -> 56 at y=31.
  task automatic test_wall();
    int n;
    speedInit = 4'd15;
    entropy   = 5'b11_000;
    cosMag    = 0;
    sinMag    = 127;
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    moveEn = 1'b1;
    n = 0;
    while (inPlayA !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({thetaA, thetaB, speedA} !== {6'd56, 6'd56, 4'd15}) begin
      testsFailed++;
      $display("[TB] FAIL wall_launch: thA=%0d thB=%0d sp=%0d, want 56 56 15",
               thetaA, thetaB, speedA);
    end
    entropy = 5'd0;
    n = 0;
    while (thetaA === 6'd56 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({thetaA, yA, xA, inPlayA} !== {6'd8, 5'd0, 5'd16, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL top_bounce: th=%0d y=%0d x=%0d ip=%b after %0d cycles, want 8 0 16 1",
               thetaA, yA, xA, inPlayA, n);
    end
    testsRun++;
    if ({thetaB, yB, inPlayB} !== {6'd56, 5'd31, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL top_wrap: th=%0d y=%0d ip=%b, want 56 31 1", thetaB, yB, inPlayB);
    end
    n = 0;
    while (thetaA === 6'd8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if ({thetaA, yA} !== {6'd56, 5'd31}) begin
      testsFailed++;
      $display("[TB] FAIL bottom_bounce: th=%0d y=%0d after %0d cycles, want 56 31",
               thetaA, yA, n);
    end
    moveEn = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_serve();
    test_paddle_hit();
    test_miss();
    test_saturation();
    test_wall();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
Parametrised successor to the pong ball integrator. It tracks the ball's fixed-point position and angular heading, and handles paddle reflection and top/bottom walls (wrap or bounce). It adds what the fixed block lacked: a serve state machine with countdown, per-hit speed-up, one-hot score pulses, a move-tick enable instead of a slow clock, and an external shared sin/cos lookup with a latency-absorbing settle state. It sits between the paddle/input logic and the VGA/dot-matrix renderer and score keeper.

Parameters:
POS_BITS, 5, integer bits per axis; field is 2^POS_BITS cells square (W = 2^POS_BITS)
FRAC_BITS, 16, fractional bits of position accumulators
THETA_WIDTH, 6, heading resolution, 2^THETA_WIDTH steps per turn
SPEED_BITS, 4, speed register width
SPEED_STEP, 1, speed added per paddle hit
SPEED_MAX, 15, speed saturation value
SERVE_TICKS, 1000, move_en ticks between serve request and launch
WALL_MODE, 1, 0 = top/bottom wrap, 1 = top/bottom bounce

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
move_en  in  1  one-cycle tick; state advances only on ticks, except reset and serve
serve  in  1  level; starts serve countdown from IDLE
speed_init  in  SPEED_BITS  speed loaded at launch
entropy  in  5  random bits for launch heading and bounce jitter
sin_i  in  8  signed sin(theta_o), 1-cycle registered lookup
cos_i  in  8  signed cos(theta_o), 1-cycle registered lookup
lpaddle  in  W  row mask of left paddle (column 0)
rpaddle  in  W  row mask of right paddle (column W-1)
x  out  POS_BITS  ball column
y  out  POS_BITS  ball row
theta_o  out  THETA_WIDTH  current heading
speed_o  out  SPEED_BITS  current speed
in_play  out  1  high in PLAY and SETTLE
score_left  out  1  1-cycle pulse: ball left through the right edge (left player scores)
score_right  out  1  1-cycle pulse: ball left through the left edge (right player scores)

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, position centre (W/2 << FRAC_BITS per axis), theta 0, speed 0, score pulses 0, in_play 0. Reset overrides everything, mid-flight included.
- Position regs are POS_BITS+FRAC_BITS wide. x/y are the top POS_BITS bits.
- dx = cos_i*speed, dy = sin_i*speed; speed is zero-extended to signed. Products are sign-extended, and sums are computed with one guard bit to detect crossing.
- Heading: moving right iff theta top two bits are 00 or 11 (cos ≥ 0). Moving down iff theta MSB = 0.
- bounce = sign-extended entropy[2:0]. Horizontal reflect: theta ← 2^(THETA_WIDTH-1) − theta + bounce. Vertical reflect: theta ← −theta + bounce. Both are mod 2^THETA_WIDTH.
- FSM:
  - IDLE: ball centred. serve=1 → SERVE, counter ← SERVE_TICKS−1.
  - SERVE: counter decrements per move_en. At 0 with move_en:
    - speed ← speed_init
    - theta ← {q, entropy[2:0]}, with q = 000/011/100/111 selected by entropy[4:3]
    - → SETTLE.
  - SETTLE: wait one move_en tick with position held, so sin_i/cos_i reflect the new theta; → PLAY.
  - PLAY, per move_en, evaluated on next position:
    - Moving left and next x == 0, or moving right and next x == W−1:
      - Paddle bit set at next y → horizontal reflect, speed ← min(speed+SPEED_STEP, SPEED_MAX), position held, → SETTLE.
      - Otherwise → OUT; score_right (left edge) or score_left (right edge) pulses in the OUT cycle.
    - Else, WALL_MODE=1 and next y guard bit indicates crossing top or bottom → vertical reflect, position held, → SETTLE.
    - WALL_MODE=0 → y wraps modulo W, theta unchanged.
    - Else → position ← next.
  - OUT: one clk cycle; position re-centred; → SERVE with counter reloaded (auto re-serve; serve input not needed).
- Priority: paddle/out over wall. A corner event applies the horizontal action only; the wall is re-evaluated after SETTLE.
- serve is ignored outside IDLE. move_en is ignored in IDLE and OUT.
- speed_o holds its value through OUT and SERVE and is reloaded at launch.

Test Plan:
- Reset: reset_n=0 for 2 cycles, POS_BITS=5 → x=16, y=16, theta_o=0, in_play=0, no score pulses.
- Serve: serve=1, SERVE_TICKS=4, entropy=5'b01_010, speed_init=3 → launch on 4th move_en tick, theta_o=6'b011010, speed_o=3. in_play rises at launch, when SETTLE is entered.
- Left paddle hit: ball moving left at x=1, next x=0, row 7, lpaddle bit 7 set, bounce=0, theta=20 → theta_o=12, speed 3→4, x stays 1, SETTLE inserted.
- Miss: same as above with lpaddle=0 → score_right high exactly 1 cycle, x=y=16 next cycle, SERVE countdown restarts.
- Wall bounce: WALL_MODE=1, moving up past y=0, theta=40, bounce=0 → theta_o=24, position held. With WALL_MODE=0 → y becomes 31, theta unchanged.
- Saturation and mid-reset: 20 consecutive paddle hits from speed 10 → speed_o saturates at 15. Then reset_n=0 in PLAY → IDLE and centred on the next edge.
